ps2_keyboard_rx: RTL
====================

# ps2_keyboard_rx

Upstream stage of the keyboard path. Deserialises PS/2 device-to-host frames from the raw `ps2_clk`/`ps2_data` lines, checks framing and parity, and buffers valid scan-code bytes in a small FIFO. It presents them on a `ready`/`data`/`nextdata_n` handshake to the scan-code processor, which turns them into ASCII.

## Interface

- `FIFO_AW`, 3: FIFO address width; the depth is 2^FIFO_AW = 8 bytes.
- `TIMEOUT_CYCLES`, 50000: number of `clk` cycles without a PS/2 falling edge, in mid-frame, that aborts the frame (1 ms at 50 MHz).

- `clk`  in  1  system clock; all state on its rising edge.
- `clrn`  in  1  asynchronous active-low reset.
- `ps2_clk`  in  1  raw PS/2 clock, asynchronous to `clk`.
- `ps2_data`  in  1  raw PS/2 data, asynchronous to `clk`.
- `nextdata_n`  in  1  active-low pop request from the consumer.
- `data`  out  8  FIFO head byte; valid while `ready`=1.
- `ready`  out  1  FIFO non-empty.
- `overflow`  out  1  sticky flag: a valid frame was dropped because the FIFO was full.
- `frame_err`  out  1  one-cycle pulse on a start, stop, parity or timeout error.

## Operation

**Synchroniser**
- `ps2_clk` and `ps2_data` each pass through a 3-flop shift register.
- A falling edge is detected when the two oldest `ps2_clk` samples are 1 then 0.
- The data bit used is the synchronised `ps2_data` sample aligned with that edge.

**Receiver FSM**
- IDLE:
  - Waits for a falling edge.
  - If the sampled bit is 0 (start bit), go to SHIFT with bit count 0.
  - If it is 1, stay in IDLE and pulse `frame_err`.
- SHIFT:
  - Each falling edge shifts one bit in, LSB first.
  - Eight data bits are captured, then the parity bit, then the stop bit.
  - On the stop-bit edge, go to CHECK.
- CHECK (one cycle):
  - The frame is valid when stop=1 and the XOR of the 8 data bits and the parity bit is 1 (odd parity).
  - A valid frame pushes the byte; an invalid frame pulses `frame_err`.
  - Always return to IDLE.
- Timeout:
  - A counter runs in SHIFT and is cleared on each falling edge.
  - When it reaches `TIMEOUT_CYCLES`-1, go to IDLE, discard the partial frame and pulse `frame_err`.

**FIFO**
- Read pointer, write pointer and count (FIFO_AW+1 bits), with pointer wrap modulo the depth.
- Pop: happens when `nextdata_n`=0 and `ready`=1. A pop with `ready`=0 is ignored.
- Push: happens when CHECK is valid and (count < depth, or a pop occurs in the same cycle).
- Simultaneous push and pop: the count is unchanged and both pointers advance.
- Valid frame with the FIFO full and no pop: the byte is dropped and `overflow` is set.
- `overflow` clears on the next pop.
- `data` is driven combinationally from `mem[rptr]`.

**Reset** (`clrn`=0, asynchronous)
- FSM goes to IDLE; bit count, timeout counter, pointers and count are cleared.
- Synchroniser flops go to 1 (the bus idle level).
- Output values: `ready`=0, `data`=8'h00, `overflow`=0, `frame_err`=0.
- FIFO memory contents are not reset; `data` is forced to 0 while empty.
- Reset in mid-frame discards the partial frame.

## Timing

- Synchroniser latency: 3 `clk` cycles from a `ps2_clk` fall to the internal edge strobe.
- The stop-bit edge strobe is at cycle N, CHECK is at N+1, the FIFO write completes at the N+2 edge, and `ready`=1 from cycle N+2 (FIFO previously empty).
- Pop: the head advances at the clock edge that samples `nextdata_n`=0. `ready` falls in the same cycle the count reaches 0.
- Sustained `nextdata_n`=0 drains one byte per cycle.
- The consumer's registered `nextdata_n` lags `ready` by one cycle. That is legal: no over-pop, because a pop requires `ready`.
- Any `TIMEOUT_CYCLES` ≥ 16 must be supported. The PS/2 bit period is ≥ 60 µs, so at `clk` ≥ 1 MHz every bit is sampled.

## Structure

- Shared package `ps2_pkg`:
  - `PS2_FRAME_BITS` = 11
  - FSM state enum {IDLE, SHIFT, CHECK}
  - scan-code constants `SC_BREAK` = 8'hF0, `SC_EXT` = 8'hE0, `SC_LSHIFT` = 8'h12, `SC_RSHIFT` = 8'h59, shared with the downstream processor.
- One sub-module, `ps2_fifo`:
  - Synchronous 2^FIFO_AW × 8 buffer.
  - push, pop, full, empty, count and head outputs.
  - Simultaneous push and pop on full is allowed.
- The receiver FSM, synchroniser and timeout counter live in the top module.

## Test plan

1. Reset, then a valid frame for 8'h1C (parity bit 0) → `ready`=1 and `data`=8'h1C 2 cycles after the stop edge strobe; `frame_err` stays 0.
2. Sequence 8'hF0, 8'h1C with `nextdata_n` held high, then pulled low for 2 cycles → reads 8'hF0 then 8'h1C; `ready`=0 afterwards.
3. Frame for 8'h1C with parity bit 1 → `frame_err` pulses once; `ready` stays 0.
4. 9 valid frames (8'h01..8'h09) with no pops → count is 8, `overflow`=1, 8'h09 is lost; the first pop yields 8'h01 and clears `overflow`.
5. With the FIFO full, a pop in the same cycle as a valid push of 8'hAA → count stays 8, `overflow` stays 0, and 8'hAA is read last.
6. 5 bits of a frame, then the bus idles for `TIMEOUT_CYCLES` → `frame_err` pulses and the FSM returns to IDLE; the next full frame for 8'h5A is received intact. Repeat with `clrn` pulsed in mid-frame → no push, all outputs 0.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: frame geometry, receiver states and the scan codes
// the downstream scan-code processor also decodes.
package ps2_pkg;

    // Start + 8 data + parity + stop.
    localparam int PS2_FRAME_BITS = 11;
    // Bits captured after the start bit: 8 data, parity, stop.
    localparam int PS2_SHIFT_BITS = PS2_FRAME_BITS - 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        CHECK = 2'd2
    } ps2_state_e;

    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;

    // Captured bits are {stop, parity, data[7:0]}; valid needs stop=1 and odd parity.
    function automatic logic frame_ok(input logic [PS2_SHIFT_BITS-1:0] bits);
        return bits[PS2_SHIFT_BITS-1] & (^bits[PS2_SHIFT_BITS-2:0]);
    endfunction

endpackage

// File: rtl/ps2_fifo.sv
// Small synchronous byte FIFO between the PS/2 receiver and its consumer.
// A push on a full FIFO is accepted when a pop happens in the same cycle.
import ps2_pkg::*;

module ps2_fifo #(
    parameter int AW = 3
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        push,
    input  logic [7:0]  push_data,
    input  logic        pop,
    output logic        full,
    output logic        empty,
    output logic [AW:0] count,
    output logic [7:0]  head
);

    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == DEPTH_C);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rptr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally modulo DEPTH.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage array is not reset; an empty FIFO never exposes it.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= push_data;
    end

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 device-to-host receiver: synchronises the raw bus, deserialises
// 11-bit frames, checks start/stop/parity with a mid-frame timeout, and
// queues good scan-code bytes for the consumer.
//
// Consumer handshake: ready=1 means data holds the oldest byte; that byte is
// consumed on a rising clk edge where nextdata_n=0 and ready=1. nextdata_n=0
// while ready=0 is ignored, so a consumer lagging ready by a cycle is safe.
import ps2_pkg::*;

module ps2_keyboard_rx #(
    parameter int FIFO_AW        = 3,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             ps2_clk,
    input  logic             ps2_data,
    input  logic             nextdata_n,
    output logic [7:0]       data,
    output logic             ready,
    output logic             overflow,
    output logic             frame_err,
    output ps2_state_e       state_dbg,
    output logic [FIFO_AW:0] fill_dbg
);

    localparam int TO_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0] LAST_BIT = 4'(PS2_SHIFT_BITS - 1);

    ps2_state_e state;
    ps2_state_e state_next;

    logic [2:0]                clk_sync;
    logic [2:0]                dat_sync;
    logic                      fall_edge;
    logic                      rx_bit;
    logic [3:0]                bit_cnt;
    logic [PS2_SHIFT_BITS-1:0] shreg;
    logic [TO_W-1:0]           to_cnt;
    logic                      shift_en;
    logic                      frame_bad;
    logic                      push_req;
    logic                      pop_fire;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic [7:0]                fifo_head;

    // Three-flop synchronisers; reset to the idle-high bus level.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            clk_sync <= 3'b111;
            dat_sync <= 3'b111;
        end else begin
            clk_sync <= {clk_sync[1:0], ps2_clk};
            dat_sync <= {dat_sync[1:0], ps2_data};
        end
    end

    // Falling edge between the two oldest clock samples; data taken from the
    // sample of the same age so both lines see identical latency.
    assign fall_edge = clk_sync[2] & ~clk_sync[1];
    assign rx_bit    = dat_sync[1];

    // Receiver state register.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state and control decode.
    always_comb begin
        state_next = state;
        shift_en   = 1'b0;
        frame_bad  = 1'b0;
        push_req   = 1'b0;
        case (state)
            IDLE: begin
                if (fall_edge) begin
                    if (!rx_bit) state_next = SHIFT;
                    else         frame_bad  = 1'b1;
                end
            end
            SHIFT: begin
                if (fall_edge) begin
                    shift_en = 1'b1;
                    if (bit_cnt == LAST_BIT) state_next = CHECK;
                end else if (to_cnt == TO_LAST) begin
                    state_next = IDLE;
                    frame_bad  = 1'b1;
                end
            end
            CHECK: begin
                state_next = IDLE;
                if (frame_ok(shreg)) push_req  = 1'b1;
                else                 frame_bad = 1'b1;
            end
            default: state_next = IDLE;
        endcase
    end

    // Shift register and bit counter; LSB arrives first so bits enter at the top.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            bit_cnt <= '0;
            shreg   <= '0;
        end else if (state == IDLE) begin
            bit_cnt <= '0;
        end else if (shift_en) begin
            shreg   <= {rx_bit, shreg[PS2_SHIFT_BITS-1:1]};
            bit_cnt <= bit_cnt + 1'b1;
        end
    end

    // Mid-frame inactivity counter; only runs while shifting.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn)                            to_cnt <= '0;
        else if (state != SHIFT || fall_edge) to_cnt <= '0;
        else                                  to_cnt <= to_cnt + 1'b1;
    end

    // Registered error pulse, one cycle per bad frame.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) frame_err <= 1'b0;
        else       frame_err <= frame_bad;
    end

    assign pop_fire = ~nextdata_n & ~fifo_empty;

    // Sticky drop flag: set when a good byte meets a full FIFO with no pop,
    // cleared by the next pop.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn)                                     overflow <= 1'b0;
        else if (pop_fire)                             overflow <= 1'b0;
        else if (push_req && fifo_full)                overflow <= 1'b1;
    end

    ps2_fifo #(
        .AW (FIFO_AW)
    ) u_fifo (
        .clk       (clk),
        .clrn      (clrn),
        .push      (push_req),
        .push_data (shreg[7:0]),
        .pop       (~nextdata_n),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fill_dbg),
        .head      (fifo_head)
    );

    assign ready     = ~fifo_empty;
    assign data      = fifo_empty ? 8'h00 : fifo_head;
    assign state_dbg = state;

endmodule
